operand_capture: RTL and testbench
==================================

# operand_capture

Sequential operand loader for the calculator datapath: it accepts a stream of single-cycle data strobes and demultiplexes them into two held operand registers, A then B. It also drives the select line that the downstream 2:1 operand mux uses. It is the writer end of the A/B/S mux interface: it fills A and B, flags when the pair is complete, and holds them until the consumer acknowledges.

## Interface
- WIDTH, 4, operand and data width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  incoming operand value
- din_valid  input  1  single-cycle strobe, din valid this cycle
- clear  input  1  synchronous abort; discards captured operands
- ack  input  1  consumer has taken the operand pair
- A  output  WIDTH  captured operand A (registered)
- B  output  WIDTH  captured operand B (registered)
- S  output  1  current target/select: 0 = A, 1 = B (registered)
- ready  output  1  both operands valid and held
- busy  output  1  A captured, B pending

## Operation
- FSM states:
  - LOAD_A: encoding 2'b00
  - LOAD_B: encoding 2'b01
  - HOLD: encoding 2'b10
  - 2'b11 is illegal and recovers to LOAD_A on the next edge.
- LOAD_A: din_valid -> A <= din, S <= 1, go to LOAD_B.
- LOAD_B: din_valid -> B <= din, S <= 0, go to HOLD.
- HOLD:
  - ready = 1; A and B frozen.
  - ack -> go to LOAD_A; A and B keep their values until overwritten.
  - din_valid in HOLD is dropped; see Configuration.
- clear, any state:
  - next state LOAD_A; A <= 0, B <= 0, S <= 0.
  - clear has priority over din_valid and ack in the same cycle.
- ack outside HOLD is ignored.
- ack and din_valid together in HOLD: ack is taken, the digit is dropped. A new digit is accepted one cycle after ready falls.
- Output decode from state:
  - busy = (state == LOAD_B)
  - ready = (state == HOLD)
- No arithmetic; values pass unmodified, full WIDTH, no sign interpretation.

## Timing
- Reset values: state LOAD_A; A = 0, B = 0, S = 0, ready = 0, busy = 0.
- Reset is asserted asynchronously and released synchronously to clk by the surrounding reset logic.
- Capture latency: din sampled on the rising edge with din_valid = 1. The new A/B value is visible the same edge (registered output, 1-cycle latency from strobe).
- ready rises on the edge that captures B and falls on the edge that samples ack.
- Minimum pair period: 3 cycles (A strobe, B strobe, ack).
- Back-to-back strobes on consecutive cycles are legal. Both are captured: A on the first, B on the second.
- Reset mid-operation (any state) returns to LOAD_A; partially captured operands are lost.

## Configuration
- OPERAND_CAPTURE_OVERRUN_EN defined:
  - Adds output ovr (1 bit, reset 0).
  - ovr sets when din_valid arrives in HOLD without a simultaneous clear.
  - ovr is sticky; it clears only on clear or rst.
- Not defined:
  - Port ovr is absent.
  - Strobes in HOLD are silently dropped.

## Structure
- Shared package calc_pkg holds:
  - the state typedef/localparams (LOAD_A, LOAD_B, HOLD)
  - the default operand width constant (4)
- One natural sub-module: operand_reg, a WIDTH-bit register with asynchronous reset, synchronous clear and load enable. It is instantiated twice, for A and for B.

## Test plan
- Reset then idle: rst pulse, no strobes -> A = 0, B = 0, S = 0, ready = 0, busy = 0.
- Normal pair: din = 5 strobe, then din = 7 strobe, then ack one cycle later:
  - A = 5 and S = 1 after the first edge.
  - B = 7, S = 0 and ready = 1 after the second edge.
  - ready = 0 after the ack edge.
- Back-to-back plus hold: strobes 14 and 15 on consecutive cycles, then strobe 3 while ready:
  - A = 14, B = 15, values unchanged.
  - With OPERAND_CAPTURE_OVERRUN_EN, ovr = 1.
- Simultaneous events:
  - clear with din_valid (din = 9) in LOAD_A -> A stays 0, state LOAD_A.
  - ack with din_valid in HOLD -> ready falls, digit dropped.
- Async reset mid-pair: A = 5 captured (busy = 1), assert rst between clock edges -> outputs zero immediately, before the next edge. The next strobe loads A.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator datapath types: operand loader states and the default operand width.
package calc_pkg;

    localparam int unsigned OPERAND_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        HOLD   = 2'b10
    } load_state_e;

endpackage

// File: rtl/operand_reg.sv
// Held operand register: async reset, synchronous clear (priority), load enable.
module operand_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (load) begin
            val_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/operand_capture.sv
// Sequential A/B operand loader driving the downstream operand mux select.
// Optional sticky overrun flag (port ovr) enabled by OPERAND_CAPTURE_OVERRUN_EN.
module operand_capture
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = OPERAND_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             clear,
    input  logic             ack,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             S,
    output logic             ready,
    output logic             busy
`ifdef OPERAND_CAPTURE_OVERRUN_EN
   ,output logic             ovr
`endif
);

    load_state_e state_d;
    load_state_e state_q;
    logic        s_d;
    logic        s_q;
    logic        load_a;
    logic        load_b;

    // clear wins over any strobe, so gate the load enables here as well
    assign load_a = (state_q == LOAD_A) && din_valid && !clear;
    assign load_b = (state_q == LOAD_B) && din_valid && !clear;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        case (state_q)
            LOAD_A: begin
                if (din_valid) begin
                    state_d = LOAD_B;
                    s_d     = 1'b1;
                end
            end
            LOAD_B: begin
                if (din_valid) begin
                    state_d = HOLD;
                    s_d     = 1'b0;
                end
            end
            HOLD: begin
                if (ack) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                s_d     = 1'b0;
            end
        endcase
        if (clear) begin
            state_d = LOAD_A;
            s_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
        end
    end

    operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .load (load_a),
        .d    (din),
        .q    (A)
    );

    operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .load (load_b),
        .d    (din),
        .q    (B)
    );

    assign S     = s_q;
    assign busy  = (state_q == LOAD_B);
    assign ready = (state_q == HOLD);

`ifdef OPERAND_CAPTURE_OVERRUN_EN
    logic ovr_d;
    logic ovr_q;

    always_comb begin
        ovr_d = ovr_q;
        if (clear) begin
            ovr_d = 1'b0;
        end else if ((state_q == HOLD) && din_valid) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_operand_capture.sv
// Directed, table-driven self-checking bench for operand_capture.
module tb_operand_capture;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         clear;
    logic         ack;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         S;
    logic         ready;
    logic         busy;
`ifdef OPERAND_CAPTURE_OVERRUN_EN
    logic         ovr;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    operand_capture #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .ack       (ack),
        .A         (A),
        .B         (B),
        .S         (S),
        .ready     (ready),
        .busy      (busy)
`ifdef OPERAND_CAPTURE_OVERRUN_EN
       ,.ovr       (ovr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic         v;
        logic         clr;
        logic         ack;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         es;
        logic         er;
        logic         ebusy;
        logic         eovr;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int unsigned idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int unsigned idx, input logic [W-1:0] ea,
                             input logic [W-1:0] eb, input logic es,
                             input logic er, input logic ebusy);
        check("A", idx, {4'b0, A}, {4'b0, ea});
        check("B", idx, {4'b0, B}, {4'b0, eb});
        check("S", idx, {7'b0, S}, {7'b0, es});
        check("ready", idx, {7'b0, ready}, {7'b0, er});
        check("busy", idx, {7'b0, busy}, {7'b0, ebusy});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          din    v     clr   ack   A      B      S     rdy   busy  ovr
        vecs[0]  = '{4'd0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd5, 1'b1, 1'b0, 1'b0, 4'd5,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'd7, 1'b1, 1'b0, 1'b0, 4'd5,  4'd7,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'd0, 1'b0, 1'b0, 1'b1, 4'd5,  4'd7,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd14,1'b1, 1'b0, 1'b0, 4'd14, 4'd7,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'd15,1'b1, 1'b0, 1'b0, 4'd14, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'd3, 1'b1, 1'b0, 1'b0, 4'd14, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4'd9, 1'b1, 1'b0, 1'b1, 4'd14, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'd2, 1'b1, 1'b0, 1'b0, 4'd2,  4'd15, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'd0, 1'b0, 1'b0, 1'b1, 4'd2,  4'd15, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'd9, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd9, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'd6, 1'b1, 1'b0, 1'b0, 4'd6,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'd8, 1'b1, 1'b0, 1'b0, 4'd6,  4'd8,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'd1, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; din = '0; din_valid = 1'b0; clear = 1'b0; ack = 1'b0;
        #1;
        check_all(100, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            din = vecs[i].din; din_valid = vecs[i].v;
            clear = vecs[i].clr; ack = vecs[i].ack;
            @(posedge clk);
            #1;
            check_all(i, vecs[i].ea, vecs[i].eb, vecs[i].es, vecs[i].er, vecs[i].ebusy);
`ifdef OPERAND_CAPTURE_OVERRUN_EN
            check("ovr", i, {7'b0, ovr}, {7'b0, vecs[i].eovr});
`endif
        end

        // Async reset between edges while B is pending
        @(negedge clk);
        din = 4'd5; din_valid = 1'b1; clear = 1'b0; ack = 1'b0;
        @(posedge clk);
        #1;
        check_all(200, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_all(201, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        din = 4'd4; din_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all(202, 4'd4, 4'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
